// File: rtl/pipe_adder.sv
// pipe_adder: unsigned W-bit adder whose carry chain is split into
// N = W/CHUNK registered stages, one CHUNK-bit adder per stage.
// Optional build macro: PIPE_ADDER_SAT_EN makes a final carry-out force
// result to all ones. c_out still reports the true carry.
//
// Handshake: a word moves in when in_valid && in_ready and moves out when
// out_valid && out_ready. The whole pipeline advances together on
// en = !out_valid || out_ready. in_ready is en, combinationally. While en
// is low, every stage register, result, c_out and out_valid hold.
module pipe_adder #(
    parameter int W     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x_0,
    input  logic [W-1:0] x_1,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         c_out
);

    localparam int N = W / CHUNK;

    if (CHUNK < 1 || (W % CHUNK) != 0) begin : g_bad_cfg
        $error("pipe_adder: W must be a positive multiple of CHUNK");
    end

    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage k adds chunk k. It passes the still-unadded upper operand
    // chunks forward and appends its sum chunk to the lower sum bits
    // already produced.
    for (genvar k = 0; k < N; k++) begin : g_stage
        localparam int RW = (N - k) * CHUNK;   // operand bits not yet added
        localparam int SW = (k + 1) * CHUNK;   // sum bits known after this stage

        logic [RW-1:0] a_src;
        logic [RW-1:0] b_src;
        logic          c_src;
        logic          v_src;
        logic [CHUNK:0] chunk_sum;
        logic [SW-1:0] s_nxt;
        logic [SW-1:0] s_load;

        logic          v_q;
        logic          c_q;
        logic [SW-1:0] s_q;

        if (k == 0) begin : g_first
            assign a_src = x_0;
            assign b_src = x_1;
            assign c_src = c_in;
            assign v_src = in_valid;
            assign s_nxt = chunk_sum[CHUNK-1:0];
        end else begin : g_next
            assign a_src = g_stage[k-1].g_ops.a_q;
            assign b_src = g_stage[k-1].g_ops.b_q;
            assign c_src = g_stage[k-1].c_q;
            assign v_src = g_stage[k-1].v_q;
            assign s_nxt = {chunk_sum[CHUNK-1:0], g_stage[k-1].s_q};
        end

        assign chunk_sum = {1'b0, a_src[CHUNK-1:0]}
                         + {1'b0, b_src[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, c_src};

        if (k == N - 1) begin : g_last
`ifdef PIPE_ADDER_SAT_EN
            assign s_load = chunk_sum[CHUNK] ? {SW{1'b1}} : s_nxt;
`else
            assign s_load = s_nxt;
`endif
        end else begin : g_mid
            assign s_load = s_nxt;
        end

        // Stage valid, carry and partial sum advance only when the pipe is enabled.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_src;
                c_q <= chunk_sum[CHUNK];
                s_q <= s_load;
            end
        end

        if (k < N - 1) begin : g_ops
            logic [RW-CHUNK-1:0] a_q;
            logic [RW-CHUNK-1:0] b_q;

            // Carry the not-yet-added operand chunks to the next stage.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_src[RW-1:CHUNK];
                    b_q <= b_src[RW-1:CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stage[N-1].v_q;
    assign result    = g_stage[N-1].s_q;
    assign c_out     = g_stage[N-1].c_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Testbench for pipe_adder at W=8, CHUNK=4 (two stages). Honors PIPE_ADDER_SAT_EN.
module tb_pipe_adder;

    localparam int W     = 8;
    localparam int CHUNK = 4;
    localparam int N     = W / CHUNK;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x_0 = '0;
    logic [W-1:0] x_1 = '0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         c_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int or_mode  = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
    bit lat_chk  = 1'b0;

    logic [W:0] exp_q[$];
    int         cyc_q[$];
    bit         lat_q[$];

    pipe_adder #(.W(W), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_0       (x_0),
        .x_1       (x_1),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain (W+1)-bit addition, optional saturation of the sum bits
    function automatic logic [W:0] model(logic [W-1:0] a, logic [W-1:0] b, logic c);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`ifdef PIPE_ADDER_SAT_EN
        if (s[W]) s[W-1:0] = '1;
`endif
        return s;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Driver: hold the operands until accepted, then push the expectation
    task automatic drive_exp(logic [W-1:0] a, logic [W-1:0] b, logic c, logic [W:0] e);
        x_0 = a;
        x_1 = b;
        c_in = c;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                exp_q.push_back(e);
                cyc_q.push_back(cyc);
                lat_q.push_back(lat_chk);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                x_0 = W'($urandom);
                x_1 = W'($urandom);
                c_in = 1'($urandom);
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL drive_timeout: in_ready never 1, expected 1");
        in_valid = 1'b0;
    endtask

    task automatic drive_one();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom_range(0, 1));
        drive_exp(a, b, c, model(a, b, c));
    endtask

    // out_ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor: the front entry must be shown whenever out_valid=1
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got 0x%0h expected no output",
                             {c_out, result});
                end else begin
                    check("result", 32'({c_out, result}), 32'(exp_q[0]));
                    if (out_ready === 1'b1) begin
                        if (lat_q[0])
                            check("latency", 32'(cyc), 32'(cyc_q[0] + N));
                        void'(exp_q.pop_front());
                        void'(cyc_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic drain();
        or_mode = 0;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) idle(1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Main stimulus
    initial begin
        resetn = 1'b0;
        idle(2);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_c_out",     32'(c_out),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        resetn = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed values, timed with out_ready held at 1
        lat_chk = 1'b1;
        or_mode = 0;
        out_ready = 1'b1;
        drive_exp(8'h3C, 8'h15, 1'b0, 9'h051);
        idle(3);
`ifdef PIPE_ADDER_SAT_EN
        drive_exp(8'hFF, 8'h01, 1'b0, 9'h1FF);
`else
        drive_exp(8'hFF, 8'h01, 1'b0, 9'h100);
`endif
        drive_exp(8'h0F, 8'h00, 1'b1, 9'h010);
        idle(4);

        // Ten back-to-back random operands
        for (int i = 0; i < 10; i++) drive_one();
        idle(4);

        // Bubble pattern 1,0,1
        drive_one();
        idle(1);
        drive_one();
        idle(4);

        // Backpressure: fill the pipe while out_ready=0, then hold 5 cycles
        lat_chk = 1'b0;
        or_mode = 2;
        out_ready = 1'b0;
        drive_one();
        drive_one();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        or_mode = 1;

        // Random traffic with random out_ready and random input gaps
        for (int i = 0; i < 40; i++) begin
            drive_one();
            idle($urandom_range(0, 2));
        end
        drain();

        // Reset mid-flight
        lat_chk = 1'b1;
        drive_one();
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        resetn = 1'b0;
        #1;
        exp_q.delete();
        cyc_q.delete();
        lat_q.delete();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result",    32'(result),    32'd0);
        check("midrst_c_out",     32'(c_out),     32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        idle(2);
        resetn = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        idle(6);
        drive_one();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
